ro_window_counter: RTL and testbench

- Parametrised, multi-channel successor to the single 12-bit enabled counter used for ring-oscillator PUF measurement.
- NUM_CH independent event counters run over a programmable measurement window controlled by an internal cycle timer. At window end, the block latches all counts and produces one PUF response bit by comparing two selected channels.
- Sits between the RO event synchronisers (one ch_en pulse per RO event) and the PUF response collector.

---
 rtl/ro_window_counter.sv | 175 +++++++++++++++++
 tb/tb_ro_window_counter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_window_counter.sv
// Multi-channel ring-oscillator event counter over a programmable window.
// At window end all counts are latched and one response bit compares two selected channels.
module ro_window_counter #(
    parameter int NUM_CH    = 8,
    parameter int WIDTH     = 12,
    parameter int WIN_WIDTH = 16,
    parameter int SATURATE  = 1,
    localparam int SELW     = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WIN_WIDTH-1:0]    window_len,
    input  logic [SELW-1:0]         sel_a,
    input  logic [SELW-1:0]         sel_b,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH*WIDTH-1:0] count_out,
    output logic [NUM_CH-1:0]       overflow,
    output logic                    resp_bit,
    output logic                    tie
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [NUM_CH-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][WIDTH-1:0] count_out_q, count_out_d;
    logic [NUM_CH-1:0]            ovf_q, ovf_d;
    logic [NUM_CH-1:0]            overflow_q, overflow_d;
    logic [WIN_WIDTH-1:0]         timer_q, timer_d;
    logic [SELW-1:0]              sel_a_q, sel_a_d;
    logic [SELW-1:0]              sel_b_q, sel_b_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         resp_q, resp_d;
    logic                         tie_q, tie_d;
    logic [WIDTH-1:0]             opa_s, opb_s;

    // Out-of-range selects (non-power-of-2 NUM_CH) read as a zero count.
    function automatic logic [WIDTH-1:0] pick_count(
        input logic [NUM_CH-1:0][WIDTH-1:0] c,
        input logic [SELW-1:0]              s
    );
        logic [WIDTH-1:0] v;
        v = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            v = (s == SELW'(i)) ? c[i] : v;
        end
        return v;
    endfunction

    assign opa_s = pick_count(cnt_q, sel_a_q);
    assign opb_s = pick_count(cnt_q, sel_b_q);

    // Next-state computation for the measurement FSM and its datapath.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        timer_d     = timer_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        count_out_d = count_out_q;
        overflow_d  = overflow_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        resp_d      = resp_q;
        tie_d       = tie_q;
        case (state_q)
            S_IDLE: begin
                if (start && (window_len != {WIN_WIDTH{1'b0}})) begin
                    cnt_d   = '0;
                    ovf_d   = {NUM_CH{1'b0}};
                    timer_d = window_len;
                    sel_a_d = sel_a;
                    sel_b_d = sel_b;
                    busy_d  = 1'b1;
                    state_d = S_COUNT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COUNT: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_en[i]) begin
                            if (cnt_q[i] == {WIDTH{1'b1}}) begin
                                ovf_d[i] = 1'b1;
                                cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : {WIDTH{1'b0}};
                            end else begin
                                cnt_d[i] = cnt_q[i] + WIDTH'(1);
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i];
                        end
                    end
                    timer_d = timer_q - WIN_WIDTH'(1);
                    if (timer_q == WIN_WIDTH'(1)) begin
                        state_d = S_LATCH;
                    end else begin
                        state_d = S_COUNT;
                    end
                end
            end
            S_LATCH: begin
                // Abort wins over publishing, so the previous results stay visible.
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    count_out_d = cnt_q;
                    overflow_d  = ovf_q;
                    resp_d      = (opa_s > opb_s);
                    tie_d       = (opa_s == opb_s);
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ovf_q       <= {NUM_CH{1'b0}};
            timer_q     <= {WIN_WIDTH{1'b0}};
            sel_a_q     <= {SELW{1'b0}};
            sel_b_q     <= {SELW{1'b0}};
            count_out_q <= '0;
            overflow_q  <= {NUM_CH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resp_q      <= 1'b0;
            tie_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            timer_q     <= timer_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            count_out_q <= count_out_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            resp_q      <= resp_d;
            tie_q       <= tie_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign count_out = count_out_q;
    assign overflow  = overflow_q;
    assign resp_bit  = resp_q;
    assign tie       = tie_q;

endmodule

// File: tb/tb_ro_window_counter.sv
// Directed bench for ro_window_counter: four instances (12-bit saturating, 4-bit saturating,
// 4-bit wrapping, 3-channel) share one stimulus; expected results flow through a scoreboard queue.
module tb_ro_window_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] window_len;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [3:0]  ch_en;

    logic        busy_m, done_m, resp_m, tie_m;
    logic [47:0] cnt_m;
    logic [3:0]  ovf_m;
    logic        busy_s, done_s, resp_s, tie_s;
    logic [15:0] cnt_s;
    logic [3:0]  ovf_s;
    logic        busy_w, done_w, resp_w, tie_w;
    logic [15:0] cnt_w;
    logic [3:0]  ovf_w;
    logic        busy_o, done_o, resp_o, tie_o;
    logic [35:0] cnt_o;
    logic [2:0]  ovf_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [47:0] cnt_m; logic [3:0] ovf_m; logic resp_m; logic tie_m;
        logic [15:0] cnt_s; logic [3:0] ovf_s; logic resp_s; logic tie_s;
        logic [15:0] cnt_w; logic [3:0] ovf_w; logic resp_w; logic tie_w;
        logic [35:0] cnt_o; logic [2:0] ovf_o; logic resp_o; logic tie_o;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_e;

    always #5 clk = ~clk;

    ro_window_counter #(.NUM_CH(4), .WIDTH(12), .WIN_WIDTH(16), .SATURATE(1)) u_main (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .window_len(window_len),
        .sel_a(sel_a), .sel_b(sel_b), .ch_en(ch_en), .busy(busy_m), .done(done_m),
        .count_out(cnt_m), .overflow(ovf_m), .resp_bit(resp_m), .tie(tie_m));

    ro_window_counter #(.NUM_CH(4), .WIDTH(4), .WIN_WIDTH(16), .SATURATE(1)) u_sat4 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .window_len(window_len),
        .sel_a(sel_a), .sel_b(sel_b), .ch_en(ch_en), .busy(busy_s), .done(done_s),
        .count_out(cnt_s), .overflow(ovf_s), .resp_bit(resp_s), .tie(tie_s));

    ro_window_counter #(.NUM_CH(4), .WIDTH(4), .WIN_WIDTH(16), .SATURATE(0)) u_wrap4 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .window_len(window_len),
        .sel_a(sel_a), .sel_b(sel_b), .ch_en(ch_en), .busy(busy_w), .done(done_w),
        .count_out(cnt_w), .overflow(ovf_w), .resp_bit(resp_w), .tie(tie_w));

    ro_window_counter #(.NUM_CH(3), .WIDTH(12), .WIN_WIDTH(16), .SATURATE(1)) u_odd3 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .window_len(window_len),
        .sel_a(sel_a), .sel_b(sel_b), .ch_en(ch_en[2:0]), .busy(busy_o), .done(done_o),
        .count_out(cnt_o), .overflow(ovf_o), .resp_bit(resp_o), .tie(tie_o));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ch_en pattern per counting edge k (1..L); bits are {ch3,ch2,ch1,ch0}.
    function automatic logic [3:0] pat(input int mode, input int k);
        logic [3:0] p;
        p = 4'h0;
        case (mode)
            0: p = {1'b1, 1'b0, 1'((k % 2) != 0), 1'b1};
            1: p = 4'hF;
            2: p = {(k == 1), 1'b0, 1'b1, (k <= 3)};
            default: p = 4'h0;
        endcase
        return p;
    endfunction

    function automatic int mcount(input int len, input int mode, input int ch,
                                  input int w, input bit sat, output bit ov);
        int c;
        int mx;
        logic [3:0] p;
        c  = 0;
        ov = 1'b0;
        mx = (1 << w) - 1;
        for (int k = 1; k <= len; k++) begin
            p = pat(mode, k);
            if (p[ch]) begin
                if (c == mx) begin
                    ov = 1'b1;
                    c  = sat ? mx : 0;
                end else begin
                    c++;
                end
            end
        end
        return c;
    endfunction

    task automatic push_expect(input int len, input int sa, input int sb, input int mode);
        exp_t e;
        int cm[4]; int cs[4]; int cw[4];
        bit om, os, ow;
        int ao, bo;
        for (int ch = 0; ch < 4; ch++) begin
            cm[ch] = mcount(len, mode, ch, 12, 1'b1, om);
            cs[ch] = mcount(len, mode, ch, 4, 1'b1, os);
            cw[ch] = mcount(len, mode, ch, 4, 1'b0, ow);
            e.cnt_m[ch*12 +: 12] = 12'(cm[ch]); e.ovf_m[ch] = om;
            e.cnt_s[ch*4 +: 4]   = 4'(cs[ch]);  e.ovf_s[ch] = os;
            e.cnt_w[ch*4 +: 4]   = 4'(cw[ch]);  e.ovf_w[ch] = ow;
            if (ch < 3) begin
                e.cnt_o[ch*12 +: 12] = 12'(cm[ch]);
                e.ovf_o[ch] = om;
            end
        end
        e.resp_m = cm[sa] > cm[sb]; e.tie_m = cm[sa] == cm[sb];
        e.resp_s = cs[sa] > cs[sb]; e.tie_s = cs[sa] == cs[sb];
        e.resp_w = cw[sa] > cw[sb]; e.tie_w = cw[sa] == cw[sb];
        ao = (sa < 3) ? cm[sa] : 0;
        bo = (sb < 3) ? cm[sb] : 0;
        e.resp_o = ao > bo; e.tie_o = ao == bo;
        sb_q.push_back(e);
    endtask

    // Entered and left at #1 after a rising edge; done is checked at exactly edge L+1.
    task automatic measure(input int len, input int sa, input int sb, input int mode);
        exp_t e;
        push_expect(len, sa, sb, mode);
        start = 1'b1; window_len = 16'(len); sel_a = 2'(sa); sel_b = 2'(sb); ch_en = 4'hF;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy_m, 1'b1);
        chk("start_nodone", done_m, 1'b0);
        for (int k = 1; k <= len; k++) begin
            ch_en = pat(mode, k);
            @(posedge clk); #1;
            chk("count_nodone", done_m, 1'b0);
        end
        ch_en = 4'hF;
        @(posedge clk); #1;
        chk("done_m", done_m, 1'b1);
        chk("busy_drop", busy_m, 1'b0);
        chk("done_all", {done_s, done_w, done_o}, 3'b111);
        chk("busy_all", {busy_s, busy_w, busy_o}, 3'b000);
        chk("sb_nonempty", 64'(sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("cnt_m", cnt_m, e.cnt_m);   chk("ovf_m", ovf_m, e.ovf_m);
            chk("resp_m", resp_m, e.resp_m); chk("tie_m", tie_m, e.tie_m);
            chk("cnt_s", cnt_s, e.cnt_s);   chk("ovf_s", ovf_s, e.ovf_s);
            chk("resp_s", resp_s, e.resp_s); chk("tie_s", tie_s, e.tie_s);
            chk("cnt_w", cnt_w, e.cnt_w);   chk("ovf_w", ovf_w, e.ovf_w);
            chk("resp_w", resp_w, e.resp_w); chk("tie_w", tie_w, e.tie_w);
            chk("cnt_o", cnt_o, e.cnt_o);   chk("ovf_o", ovf_o, e.ovf_o);
            chk("resp_o", resp_o, e.resp_o); chk("tie_o", tie_o, e.tie_o);
            last_e = e;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; window_len = 16'd0;
        sel_a = 2'd0; sel_b = 2'd0; ch_en = 4'h0;
        #2;
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_done", done_m, 1'b0);
        chk("rst_cnt", cnt_m, 48'd0);
        chk("rst_flags", {ovf_m, resp_m, tie_m}, 6'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic count, tie via equal channels, self-select, saturate vs wrap, mixed counts.
        measure(10, 0, 1, 0);
        measure(10, 0, 3, 0);
        measure(10, 2, 2, 0);
        measure(20, 0, 1, 1);
        measure(7, 1, 0, 2);
        chk("basic_anchor", last_e.cnt_m, {12'd1, 12'd0, 12'd7, 12'd3});

        // Abort mid-count with an ignored start at cycle 5.
        @(posedge clk); #1;
        start = 1'b1; window_len = 16'd50; sel_a = 2'd2; sel_b = 2'd3; ch_en = 4'hF;
        @(posedge clk); #1;
        start = 1'b0;
        chk("abt_busy", busy_m, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            start = (k == 5);
            window_len = (k == 5) ? 16'd3 : 16'd50;
            abort = (k == 20);
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            chk("abt_nodone", done_m, 1'b0);
        end
        chk("abt_busy_drop", busy_m, 1'b0);
        chk("abt_cnt_kept", cnt_m, last_e.cnt_m);
        chk("abt_resp_kept", {resp_m, tie_m}, {last_e.resp_m, last_e.tie_m});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abt_idle", {busy_m, done_m}, 2'b00);
        end

        // Asynchronous reset between edges during a long window.
        start = 1'b1; window_len = 16'd30; sel_a = 2'd0; sel_b = 2'd1; ch_en = 4'hF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_busy", busy_m, 1'b0);
        chk("arst_done", done_m, 1'b0);
        chk("arst_cnt", cnt_m, 48'd0);
        chk("arst_flags", {ovf_m, resp_m, tie_m}, 6'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("arst_idle", busy_m, 1'b0);
        measure(1, 0, 1, 1);

        // Zero-length window is ignored.
        start = 1'b1; window_len = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_busy", busy_m, 1'b0);
        chk("zero_done", done_m, 1'b0);
        @(posedge clk); #1;
        chk("zero_idle", {busy_m, done_m}, 2'b00);

        // Back-to-back: second start lands in the cycle done is high.
        measure(1, 3, 2, 1);
        measure(1, 2, 1, 0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
